// File: rtl/dmem_mmio_pkg.sv
// Shared constants and helpers for the data-memory / MMIO backend.
// Register offsets are word-aligned byte offsets inside the peripheral window.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

    localparam logic [7:0] MTIME_LO    = 8'h00;
    localparam logic [7:0] MTIME_HI    = 8'h04;
    localparam logic [7:0] MTIMECMP_LO = 8'h08;
    localparam logic [7:0] MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] CONSOLE     = 8'h10;
    localparam logic [7:0] STATUS      = 8'h14;

    function automatic logic [31:0] mergeBytes(
        input logic [31:0] oldWord,
        input logic [31:0] newWord,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = newWord[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// MEM-stage data bus between the datapath (master) and the memory backend.
// rdata is combinational from addr on the slave side.
interface dmem_mmio_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  amp;
    logic [31:0] rdata;

    modport master (
        output addr, wdata, we, amp,
        input  rdata
    );

    modport slave (
        input  addr, wdata, we, amp,
        output rdata
    );

endinterface

// File: rtl/dmem_ram.sv
// Byte-writable data RAM: asynchronous word read, synchronous masked write.
// Contents are intentionally not reset.
module dmem_ram #(
    parameter int WORDS = 1024,
    parameter int IDXW  = 10
) (
    input  logic            clk,
    input  logic [IDXW-1:0] idx,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wmask,
    output logic [31:0]     rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_mmio.sv
// MEM-stage backend: data RAM plus a 256-byte peripheral window holding
// a 64-bit machine timer with compare interrupt and a console output port.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
    parameter int          TICK_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_mmio_if.slave bus,
    output logic       timer_irq,
    output logic       console_valid,
    output logic [7:0] console_data
);

    localparam int IDXW = $clog2(DMEM_WORDS);
    localparam int PSW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

    logic        mmioHit;
    logic [7:0]  regOff;
    logic [31:0] alignedData;
    logic [3:0]  laneEn;
    logic [3:0]  ramMask;
    logic [3:0]  mmioMask;
    logic [31:0] ramRdata;
    logic [31:0] mmioRdata;

    logic [63:0]    mtime;
    logic [63:0]    mtimecmp;
    logic [PSW-1:0] prescale;

    logic selLo, selHi, selCmpLo, selCmpHi, selCon, selStat;
    logic wrLo, wrHi, wrCmpLo, wrCmpHi, conWr;

    assign mmioHit     = bus.addr[31:8] == MMIO_BASE[31:8];
    assign regOff      = {bus.addr[7:2], 2'b00};
    assign alignedData = bus.wdata << {bus.addr[1:0], 3'b000};
    // Stores presented while reset is high never reach RAM or registers.
    assign laneEn      = (bus.we && !reset) ? bus.amp : 4'b0000;
    assign ramMask     = mmioHit ? 4'b0000 : laneEn;
    assign mmioMask    = mmioHit ? laneEn : 4'b0000;

    assign selLo    = regOff == MTIME_LO;
    assign selHi    = regOff == MTIME_HI;
    assign selCmpLo = regOff == MTIMECMP_LO;
    assign selCmpHi = regOff == MTIMECMP_HI;
    assign selCon   = regOff == CONSOLE;
    assign selStat  = regOff == STATUS;

    assign wrLo    = selLo && (mmioMask != 4'b0000);
    assign wrHi    = selHi && (mmioMask != 4'b0000);
    assign wrCmpLo = selCmpLo && (mmioMask != 4'b0000);
    assign wrCmpHi = selCmpHi && (mmioMask != 4'b0000);
    assign conWr   = selCon && mmioMask[0];

    dmem_ram #(
        .WORDS (DMEM_WORDS),
        .IDXW  (IDXW)
    ) uRam (
        .clk   (clk),
        .idx   (bus.addr[IDXW+1:2]),
        .wdata (alignedData),
        .wmask (ramMask),
        .rdata (ramRdata)
    );

    always_comb begin
        mmioRdata = '0;
        unique case (1'b1)
            selLo:    mmioRdata = mtime[31:0];
            selHi:    mmioRdata = mtime[63:32];
            selCmpLo: mmioRdata = mtimecmp[31:0];
            selCmpHi: mmioRdata = mtimecmp[63:32];
            selCon:   mmioRdata = {24'b0, console_data};
            selStat:  mmioRdata = {31'b0, timer_irq};
            default:  mmioRdata = '0;
        endcase
    end

    assign bus.rdata = mmioHit ? mmioRdata : ramRdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime         <= '0;
            mtimecmp      <= '1;
            prescale      <= '0;
            timer_irq     <= 1'b0;
            console_valid <= 1'b0;
            console_data  <= '0;
        end else begin
            timer_irq <= mtime >= mtimecmp;
            // A software write to mtime suppresses that cycle's tick.
            if (wrLo || wrHi) begin
                if (wrLo) mtime[31:0]  <= mergeBytes(mtime[31:0], alignedData, mmioMask);
                if (wrHi) mtime[63:32] <= mergeBytes(mtime[63:32], alignedData, mmioMask);
                prescale <= '0;
            end else if (prescale == PS_LAST) begin
                mtime    <= mtime + 64'd1;
                prescale <= '0;
            end else begin
                prescale <= prescale + PSW'(1);
            end
            if (wrCmpLo) mtimecmp[31:0]  <= mergeBytes(mtimecmp[31:0], alignedData, mmioMask);
            if (wrCmpHi) mtimecmp[63:32] <= mergeBytes(mtimecmp[63:32], alignedData, mmioMask);
            console_valid <= conWr;
            if (conWr) console_data <= alignedData[7:0];
        end
    end

endmodule
